// File: rtl/fib_checker.sv
// rtl/fib_checker.sv - Fibonacci stream checker: seeds, per-term sum check, sticky pass/fail status
module fib_checker #(
    parameter int W      = 6,
    parameter int TARGET = 12,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic [W-1:0]     in_data,
    output logic             in_ready,
    output logic             busy,
    output logic [W-1:0]     exp_next,
    output logic [CNT_W-1:0] term_cnt,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] err_index,
    output logic [W-1:0]     err_expected,
    output logic [W-1:0]     err_got
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SEED0 = 3'd1,
        SEED1 = 3'd2,
        CHECK = 3'd3,
        PASS  = 3'd4,
        FAIL  = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] TARGET_C = CNT_W'(TARGET);
    localparam logic [CNT_W-1:0] ONE_C    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] TWO_C    = CNT_W'(2);

    state_t           state_q, state_d;
    logic [W-1:0]     prev0_q, prev0_d;
    logic [W-1:0]     prev1_q, prev1_d;
    logic [CNT_W-1:0] term_cnt_q, term_cnt_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] err_index_q, err_index_d;
    logic [W-1:0]     err_expected_q, err_expected_d;
    logic [W-1:0]     err_got_q, err_got_d;

    // Sum of the two history terms; the W-bit result drops the carry to match the generator's wrap
    logic [W-1:0]     sum_w;
    logic [CNT_W-1:0] cnt_inc_w;
    assign sum_w     = prev0_q + prev1_q;
    assign cnt_inc_w = term_cnt_q + ONE_C;

    // Next-state and status update; start overrides everything and swallows a same-cycle term
    always_comb begin
        state_d        = state_q;
        prev0_d        = prev0_q;
        prev1_d        = prev1_q;
        term_cnt_d     = term_cnt_q;
        done_d         = done_q;
        err_d          = err_q;
        err_index_d    = err_index_q;
        err_expected_d = err_expected_q;
        err_got_d      = err_got_q;
        if (start) begin
            state_d        = SEED0;
            prev0_d        = '0;
            prev1_d        = '0;
            term_cnt_d     = '0;
            done_d         = 1'b0;
            err_d          = 1'b0;
            err_index_d    = '0;
            err_expected_d = '0;
            err_got_d      = '0;
        end else if (in_valid) begin
            case (state_q)
                SEED0: begin
                    prev0_d    = in_data;
                    term_cnt_d = ONE_C;
                    state_d    = SEED1;
                end
                SEED1: begin
                    prev1_d    = in_data;
                    term_cnt_d = TWO_C;
                    state_d    = CHECK;
                end
                CHECK: begin
                    if (in_data == sum_w) begin
                        prev0_d    = prev1_q;
                        prev1_d    = in_data;
                        term_cnt_d = cnt_inc_w;
                        if (cnt_inc_w == TARGET_C) begin
                            done_d  = 1'b1;
                            state_d = PASS;
                        end
                    end else begin
                        err_d          = 1'b1;
                        err_index_d    = term_cnt_q;
                        err_expected_d = sum_w;
                        err_got_d      = in_data;
                        state_d        = FAIL;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    // State and status registers with synchronous reset to all-zero / IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            prev0_q        <= '0;
            prev1_q        <= '0;
            term_cnt_q     <= '0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
            err_index_q    <= '0;
            err_expected_q <= '0;
            err_got_q      <= '0;
        end else begin
            state_q        <= state_d;
            prev0_q        <= prev0_d;
            prev1_q        <= prev1_d;
            term_cnt_q     <= term_cnt_d;
            done_q         <= done_d;
            err_q          <= err_d;
            err_index_q    <= err_index_d;
            err_expected_q <= err_expected_d;
            err_got_q      <= err_got_d;
        end
    end

    assign in_ready     = (state_q == SEED0) || (state_q == SEED1) || (state_q == CHECK);
    assign busy         = in_ready;
    assign exp_next     = (state_q == CHECK) ? sum_w : '0;
    assign term_cnt     = term_cnt_q;
    assign done         = done_q;
    assign err          = err_q;
    assign err_index    = err_index_q;
    assign err_expected = err_expected_q;
    assign err_got      = err_got_q;

endmodule

// File: tb/tb_fib_checker.sv
// tb/tb_fib_checker.sv - scoreboard bench for fib_checker
module tb_fib_checker;

    localparam int W      = 6;
    localparam int TARGET = 12;
    localparam int CNT_W  = 8;
    localparam int OBS_W  = 4 + 2 * CNT_W + 3 * W;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             in_valid;
    logic [W-1:0]     in_data;
    logic             in_ready;
    logic             busy;
    logic [W-1:0]     exp_next;
    logic [CNT_W-1:0] term_cnt;
    logic             done;
    logic             err;
    logic [CNT_W-1:0] err_index;
    logic [W-1:0]     err_expected;
    logic [W-1:0]     err_got;

    int n_chk  = 0;
    int n_fail = 0;

    logic [OBS_W-1:0] exp_q[$];
    logic [OBS_W-1:0] obs_q[$];
    logic [OBS_W-1:0] obs_w;

    // Reference model state: 0 IDLE, 1 SEED0, 2 SEED1, 3 CHECK, 4 PASS, 5 FAIL
    int           m_state;
    logic [W-1:0] m_p0, m_p1, m_eexp, m_egot;
    int           m_cnt, m_idx;
    logic         m_done, m_err;

    fib_checker #(.W(W), .TARGET(TARGET), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .busy(busy), .exp_next(exp_next), .term_cnt(term_cnt),
        .done(done), .err(err), .err_index(err_index), .err_expected(err_expected),
        .err_got(err_got)
    );

    always #5 clk = ~clk;

    assign obs_w = {in_ready, busy, done, err, term_cnt, err_index, err_expected, err_got, exp_next};

    function automatic logic [OBS_W-1:0] model_pack();
        logic         rdy;
        logic [W-1:0] en;
        rdy = (m_state >= 1) && (m_state <= 3);
        en  = (m_state == 3) ? W'(m_p0 + m_p1) : '0;
        return {rdy, rdy, m_done, m_err, CNT_W'(m_cnt), CNT_W'(m_idx), m_eexp, m_egot, en};
    endfunction

    task automatic model_clear();
        m_p0 = '0; m_p1 = '0; m_cnt = 0; m_idx = 0;
        m_done = 1'b0; m_err = 1'b0; m_eexp = '0; m_egot = '0;
    endtask

    // Drive one cycle, advance the model, push its prediction, capture the DUT after the edge
    task automatic cycle(input logic r, input logic s, input logic v, input logic [W-1:0] d);
        logic [W-1:0] e;
        rst = r; start = s; in_valid = v; in_data = d;
        if (r) begin
            model_clear(); m_state = 0;
        end else if (s) begin
            model_clear(); m_state = 1;
        end else if (v) begin
            case (m_state)
                1: begin m_p0 = d; m_cnt = 1; m_state = 2; end
                2: begin m_p1 = d; m_cnt = 2; m_state = 3; end
                3: begin
                    e = W'(m_p0 + m_p1);
                    if (d == e) begin
                        m_p0 = m_p1; m_p1 = d; m_cnt = m_cnt + 1;
                        if (m_cnt == TARGET) begin m_done = 1'b1; m_state = 4; end
                    end else begin
                        m_err = 1'b1; m_idx = m_cnt; m_eexp = e; m_egot = d; m_state = 5;
                    end
                end
                default: ;
            endcase
        end
        exp_q.push_back(model_pack());
        @(posedge clk);
        @(negedge clk);
        obs_q.push_back(obs_w);
        rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
    endtask

    task automatic feed(input int vals[]);
        foreach (vals[i]) cycle(1'b0, 1'b0, 1'b1, W'(vals[i]));
    endtask

    task automatic test_reset();
        cycle(1'b1, 1'b0, 1'b0, '0);
        cycle(1'b1, 1'b1, 1'b1, 6'd5);
        cycle(1'b0, 1'b0, 1'b1, 6'd5);
        n_chk++;
        if (obs_w !== '0) begin
            n_fail++; $display("FAIL reset_idle got %h exp 0", obs_w);
        end
        while (obs_q.size() > 0) begin
            logic [OBS_W-1:0] o, x;
            o = obs_q.pop_front(); x = exp_q.pop_front(); n_chk++;
            if (o !== x) begin n_fail++; $display("FAIL reset_sb got %h exp %h", o, x); end
        end
    endtask

    task automatic test_pass();
        cycle(1'b0, 1'b1, 1'b0, '0);
        feed('{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 25});
        n_chk++;
        if (done !== 1'b1 || err !== 1'b0 || term_cnt !== 8'd12 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL pass_status got done=%b err=%b cnt=%0d rdy=%b exp 1 0 12 0", done, err, term_cnt, in_ready);
        end
        feed('{34});
        n_chk++;
        if (term_cnt !== 8'd12 || done !== 1'b1) begin
            n_fail++; $display("FAIL pass_sticky got cnt=%0d done=%b exp 12 1", term_cnt, done);
        end
        while (obs_q.size() > 0) begin
            logic [OBS_W-1:0] o, x;
            o = obs_q.pop_front(); x = exp_q.pop_front(); n_chk++;
            if (o !== x) begin n_fail++; $display("FAIL pass_sb got %h exp %h", o, x); end
        end
    endtask

    task automatic test_mismatch();
        logic [OBS_W-1:0] snap;
        cycle(1'b0, 1'b1, 1'b0, '0);
        feed('{0, 1, 1, 2, 4});
        n_chk++;
        if (err !== 1'b1 || done !== 1'b0 || err_index !== 8'd4 || err_expected !== 6'd3 || err_got !== 6'd4) begin
            n_fail++;
            $display("FAIL mismatch_diag got err=%b done=%b idx=%0d exp=%0d got=%0d want 1 0 4 3 4",
                     err, done, err_index, err_expected, err_got);
        end
        snap = obs_w;
        feed('{7});
        n_chk++;
        if (obs_w !== snap) begin
            n_fail++; $display("FAIL fail_sticky got %h exp %h", obs_w, snap);
        end
        while (obs_q.size() > 0) begin
            logic [OBS_W-1:0] o, x;
            o = obs_q.pop_front(); x = exp_q.pop_front(); n_chk++;
            if (o !== x) begin n_fail++; $display("FAIL mismatch_sb got %h exp %h", o, x); end
        end
    endtask

    task automatic test_reset_from_fail();
        cycle(1'b1, 1'b0, 1'b0, '0);
        n_chk++;
        if (obs_w !== '0) begin
            n_fail++; $display("FAIL rst_fail got %h exp 0", obs_w);
        end
        feed('{1, 2, 3});
        n_chk++;
        if (obs_w !== '0) begin
            n_fail++; $display("FAIL rst_ignore got %h exp 0", obs_w);
        end
        while (obs_q.size() > 0) begin
            logic [OBS_W-1:0] o, x;
            o = obs_q.pop_front(); x = exp_q.pop_front(); n_chk++;
            if (o !== x) begin n_fail++; $display("FAIL rstfail_sb got %h exp %h", o, x); end
        end
    endtask

    task automatic test_gap();
        cycle(1'b0, 1'b1, 1'b0, '0);
        feed('{2, 3, 5});
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 6'(i));
            n_chk++;
            if (term_cnt !== 8'd3) begin
                n_fail++; $display("FAIL gap_hold got %0d exp 3", term_cnt);
            end
        end
        feed('{8, 13});
        n_chk++;
        if (term_cnt !== 8'd5 || exp_next !== 6'd21 || in_ready !== 1'b1 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL gap_end got cnt=%0d exp_next=%0d rdy=%b err=%b want 5 21 1 0", term_cnt, exp_next, in_ready, err);
        end
        while (obs_q.size() > 0) begin
            logic [OBS_W-1:0] o, x;
            o = obs_q.pop_front(); x = exp_q.pop_front(); n_chk++;
            if (o !== x) begin n_fail++; $display("FAIL gap_sb got %h exp %h", o, x); end
        end
    endtask

    task automatic test_restart();
        cycle(1'b0, 1'b1, 1'b0, '0);
        feed('{0, 1, 1});
        cycle(1'b0, 1'b1, 1'b1, 6'd9);
        n_chk++;
        if (term_cnt !== 8'd0 || in_ready !== 1'b1 || exp_next !== 6'd0) begin
            n_fail++; $display("FAIL restart_drop got cnt=%0d rdy=%b en=%0d want 0 1 0", term_cnt, in_ready, exp_next);
        end
        feed('{9, 9});
        n_chk++;
        if (exp_next !== 6'd18 || term_cnt !== 8'd2) begin
            n_fail++; $display("FAIL restart_seed got en=%0d cnt=%0d want 18 2", exp_next, term_cnt);
        end
        while (obs_q.size() > 0) begin
            logic [OBS_W-1:0] o, x;
            o = obs_q.pop_front(); x = exp_q.pop_front(); n_chk++;
            if (o !== x) begin n_fail++; $display("FAIL restart_sb got %h exp %h", o, x); end
        end
    endtask

    task automatic test_wrap();
        cycle(1'b0, 1'b1, 1'b0, '0);
        feed('{63, 63});
        n_chk++;
        if (exp_next !== 6'd62) begin
            n_fail++; $display("FAIL wrap_exp got %0d exp 62", exp_next);
        end
        feed('{62});
        n_chk++;
        if (err !== 1'b0 || term_cnt !== 8'd3) begin
            n_fail++; $display("FAIL wrap_pass got err=%b cnt=%0d want 0 3", err, term_cnt);
        end
        cycle(1'b0, 1'b1, 1'b0, '0);
        feed('{63, 63, 63});
        n_chk++;
        if (err !== 1'b1 || err_expected !== 6'd62 || err_got !== 6'd63 || err_index !== 8'd2) begin
            n_fail++;
            $display("FAIL wrap_fail got err=%b exp=%0d got=%0d idx=%0d want 1 62 63 2", err, err_expected, err_got, err_index);
        end
        while (obs_q.size() > 0) begin
            logic [OBS_W-1:0] o, x;
            o = obs_q.pop_front(); x = exp_q.pop_front(); n_chk++;
            if (o !== x) begin n_fail++; $display("FAIL wrap_sb got %h exp %h", o, x); end
        end
    endtask

    task automatic test_back_to_back();
        // Zero seeds run to completion back to back, then a restart with random data
        cycle(1'b0, 1'b1, 1'b0, '0);
        for (int i = 0; i < TARGET; i++) cycle(1'b0, 1'b0, 1'b1, '0);
        n_chk++;
        if (done !== 1'b1 || term_cnt !== 8'(TARGET)) begin
            n_fail++; $display("FAIL zero_seed got done=%b cnt=%0d want 1 %0d", done, term_cnt, TARGET);
        end
        cycle(1'b0, 1'b1, 1'b1, 6'd1);
        n_chk++;
        if (done !== 1'b0 || term_cnt !== 8'd0) begin
            n_fail++; $display("FAIL pass_restart got done=%b cnt=%0d want 0 0", done, term_cnt);
        end
        feed('{0, 0, 1});
        n_chk++;
        if (err !== 1'b1 || err_index !== 8'd2 || err_expected !== 6'd0 || err_got !== 6'd1) begin
            n_fail++; $display("FAIL zero_fail got err=%b idx=%0d exp=%0d got=%0d want 1 2 0 1", err, err_index, err_expected, err_got);
        end
        cycle(1'b0, 1'b1, 1'b0, '0);
        for (int i = 0; i < 20; i++)
            cycle(1'b0, 1'b0, 1'($urandom_range(1)), 6'($urandom_range(63)));
        while (obs_q.size() > 0) begin
            logic [OBS_W-1:0] o, x;
            o = obs_q.pop_front(); x = exp_q.pop_front(); n_chk++;
            if (o !== x) begin n_fail++; $display("FAIL b2b_sb got %h exp %h", o, x); end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
        m_state = 0;
        model_clear();
        @(negedge clk);
        test_reset();
        test_pass();
        test_mismatch();
        test_reset_from_fail();
        test_gap();
        test_restart();
        test_wrap();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fib_checker.md
Name: fib_checker

Overview:
Consumer-side counterpart to the Fibonacci generator. It accepts a stream of W-bit terms, captures the first two as seeds, and checks that every later term equals the sum of the previous two modulo 2^W. It reports pass (done) after TARGET terms, or a sticky failure with diagnostics. It sits at the generator's result output, in the bench and on-board, as a self-check.

Parameters:
W, 6, term width; arithmetic is modulo 2^W, matching the generator's wrap
TARGET, 12, total terms (seeds included) to accept before done; legal range 3..2^CNT_W-1
CNT_W, 8, width of term counter and err_index

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, synchronous, active-high
start  in  1  single-cycle pulse; clears status and arms the checker
in_valid  in  1  in_data carries a term this cycle
in_data  in  W  term value
in_ready  out  1  checker is consuming terms (states SEED0, SEED1, CHECK)
busy  out  1  same as in_ready; separate port for status LEDs
exp_next  out  W  (prev0+prev1) mod 2^W; meaningful only in CHECK
term_cnt  out  CNT_W  number of terms accepted so far
done  out  1  level; TARGET terms accepted with no mismatch
err  out  1  level; sticky mismatch flag
err_index  out  CNT_W  0-based index of the failing term
err_expected  out  W  expected value at the failure
err_got  out  W  received value at the failure

Behaviour:
- States: IDLE, SEED0, SEED1, CHECK, PASS, FAIL.
- rst=1 at an edge puts the block in IDLE and zeroes every output and internal register. This applies mid-stream too; reset beats start and in_valid.
- start=1, not in reset, from any state:
  - Go to SEED0.
  - Clear term_cnt, done, err, err_index, err_expected, err_got and both history registers.
  - Any in_valid in the same cycle is discarded.
- IDLE: in_valid ignored; in_ready=0.
- SEED0: on in_valid, prev0<=in_data, term_cnt<=1, go to SEED1.
- SEED1: on in_valid, prev1<=in_data, term_cnt<=2, go to CHECK.
- CHECK: exp_next is combinational from prev0+prev1, truncated to W bits (carry discarded). On in_valid:
  - Match (in_data==exp_next):
    - prev0<=prev1, prev1<=in_data, term_cnt<=term_cnt+1.
    - If term_cnt+1==TARGET, go to PASS; done is 1 from the next cycle.
  - Mismatch:
    - Go to FAIL.
    - err<=1, err_index<=term_cnt, err_expected<=exp_next, err_got<=in_data.
    - term_cnt is not incremented.
- in_valid=0 in any state: no change. Gaps of any length are legal.
- PASS and FAIL are sticky. in_valid is ignored and in_ready=0. Only start or rst leaves these states.
- done and err are never 1 together.
- Latency: a status update is visible on the edge after the accepting in_valid cycle.
- Seeds are unrestricted: any values, including 0,0, are legal. A 0,0 seed requires all zeros after it.
- exp_next outside CHECK drives 0.
- term_cnt never exceeds TARGET.

Test Plan:
- Reset, start, feed 0,1,1,2,3,5,8,13,21,34,55,25 (W=6, 34+55=89 wraps to 25) -> done=1 one cycle after the 12th term; term_cnt=12, err=0, in_ready=0.
- Start, feed 0,1,1,2,4 -> err=1, err_index=4, err_expected=3, err_got=4, done=0. A further term 7 leaves all outputs unchanged.
- Start, feed 2,3,5 then in_valid=0 for 10 cycles, then 8,13 -> term_cnt=5 with no change during the gap, state still CHECK, exp_next=21.
- Mid-stream after 0,1,1: start pulse with in_valid=1, in_data=9 -> that sample is dropped and term_cnt=0. Next terms 9,9 are taken as seeds, and exp_next=18.
- From the FAIL state of the second scenario, rst=1 for one cycle -> all outputs 0 and state IDLE. in_valid afterwards is ignored until start.
- Seeds 63,63 -> exp_next=62 (126 mod 64). Feeding 62 passes and feeding 63 fails with err_expected=62.
